// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Stall/flush sequencer for the five-stage RV32I pipeline.
//            Define PIPE_PERF_EN to add saturating performance counters.
// Revision : 1.0
// ============================================================================
module pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_br_taken,
  input  logic              imem_req,
  input  logic              imem_resp,
  input  logic              dmem_req,
  input  logic              dmem_resp,
  output logic              load_pc,
  output logic              load_if_id,
  output logic              load_id_ex,
  output logic              load_ex_mem,
  output logic              load_mem_wb,
  output logic              hazard_stall,
  output logic              true_branch
`ifdef PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt,
  output logic [PERF_W-1:0] perf_lu_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] c_FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t     r_state, w_eff_state, w_next_state;
  logic [1:0] r_flush_cnt, w_next_cnt;
  logic       r_ret_flush, w_next_ret;
  logic       w_mstall, w_lu, w_front_en, w_back_en;

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush_cycles
    $error("pipeline_ctrl: FLUSH_CYCLES must be 1..3");
  end

  assign w_mstall = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);
  assign w_lu     = ex_is_load & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));

  always_comb begin
    // Leaving MEM_WAIT resolves to the resumed state within the same cycle.
    w_eff_state = r_state;
    if (r_state == MEM_WAIT && !w_mstall)
      w_eff_state = r_ret_flush ? FLUSH : RUN;

    w_next_state = w_eff_state;
    w_next_cnt   = r_flush_cnt;
    w_next_ret   = r_ret_flush;
    w_front_en   = 1'b1;
    w_back_en    = 1'b1;
    hazard_stall = 1'b0;
    true_branch  = 1'b0;

    if (w_mstall) begin
      w_front_en   = 1'b0;
      w_back_en    = 1'b0;
      w_next_state = MEM_WAIT;
      if (r_state != MEM_WAIT)
        w_next_ret = (r_state == FLUSH);
    end else begin
      case (w_eff_state)
        FLUSH: begin
          true_branch = 1'b1;
          if (ex_br_taken) begin
            w_next_cnt = c_FLUSH_RELOAD;
          end else if (r_flush_cnt <= 2'd1) begin
            w_next_state = RUN;
            w_next_cnt   = 2'd0;
          end else begin
            w_next_cnt = r_flush_cnt - 2'd1;
          end
        end
        default: begin
          if (ex_br_taken) begin
            true_branch = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_next_state = FLUSH;
              w_next_cnt   = c_FLUSH_RELOAD;
            end
          end else if (w_lu) begin
            w_front_en   = 1'b0;
            hazard_stall = 1'b1;
          end
        end
      endcase
    end
  end

  assign load_pc     = w_front_en;
  assign load_if_id  = w_front_en;
  assign load_id_ex  = w_back_en;
  assign load_ex_mem = w_back_en;
  assign load_mem_wb = w_back_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_flush_cnt <= 2'd0;
      r_ret_flush <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_next_cnt;
      r_ret_flush <= w_next_ret;
    end
  end

`ifdef PIPE_PERF_EN
  localparam logic [PERF_W-1:0] c_PERF_MAX = '1;
  localparam logic [PERF_W-1:0] c_PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_lu_cnt    <= '0;
    end else begin
      if (w_mstall && perf_stall_cnt != c_PERF_MAX)
        perf_stall_cnt <= perf_stall_cnt + c_PERF_ONE;
      if (true_branch && perf_flush_cnt != c_PERF_MAX)
        perf_flush_cnt <= perf_flush_cnt + c_PERF_ONE;
      if (hazard_stall && perf_lu_cnt != c_PERF_MAX)
        perf_lu_cnt <= perf_lu_cnt + c_PERF_ONE;
    end
  end
`else
  if (PERF_W < 1) begin : g_bad_perf_w
    $error("pipeline_ctrl: PERF_W must be positive");
  end
`endif

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage RV32I pipeline. It compares the ID-stage source registers against the EX-stage destination to detect load-use hazards, and freezes the whole pipe while instruction or data memory is outstanding. It also runs a multi-cycle flush window after a taken branch or jump. Outputs drive the per-stage register load enables and the ID stage's `hazard_stall` / `true_branch` bubble inputs.

## Interface

Parameters
- `FLUSH_CYCLES`, default 1: cycles `true_branch` is held after a taken redirect; legal range 1..3.
- `PERF_W`, default 32: width of each performance counter.

Ports
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `id_rs1`, `id_rs2`  in  5 each  source register indices of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the ID instruction reads that source.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_is_load`  in  1  the instruction in EX is a load.
- `ex_br_taken`  in  1  the branch/jal/jalr in EX redirects the PC this cycle.
- `imem_req`, `imem_resp`  in  1 each  instruction memory request and completion.
- `dmem_req`, `dmem_resp`  in  1 each  data memory request and completion.
- `load_pc`, `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb`  out  1 each  pipeline register enables.
- `hazard_stall`  out  1  forces a bubble in ID.
- `true_branch`  out  1  squashes the wrong-path instruction in ID.
- `perf_stall_cnt`, `perf_flush_cnt`, `perf_lu_cnt`  out  `PERF_W` each  present only with `PIPE_PERF_EN`.

## Operation

Derived terms (combinational):
- `mstall = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp)`
- `lu = ex_is_load & (ex_rd != 0) & ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2))`

State machine:
- States: `RUN`, `FLUSH`, `MEM_WAIT`.
- Registers: `flush_cnt` (2 bits) and `ret_flush` (1 bit).

Priority in every state: `mstall` first, then redirect/flush, then `lu`.

- **RUN**
  - If `mstall`: all enables 0; `hazard_stall` and `true_branch` 0; go to `MEM_WAIT` with `ret_flush = 0`.
  - Else if `ex_br_taken`: all enables 1; `true_branch` 1. If `FLUSH_CYCLES > 1`, go to `FLUSH` with `flush_cnt = FLUSH_CYCLES-1`; otherwise stay in `RUN`.
  - Else if `lu`: `load_pc` and `load_if_id` 0; the other three enables 1; `hazard_stall` 1; stay in `RUN`.
  - Else: all enables 1; both bubble outputs 0.
- **FLUSH**
  - If `mstall`: all enables 0; `true_branch` 0; go to `MEM_WAIT` with `ret_flush = 1`; `flush_cnt` frozen.
  - Else: all enables 1; `true_branch` 1; `hazard_stall` 0 (`lu` is ignored because the ID instruction is wrong-path); decrement `flush_cnt`.
  - When `flush_cnt` reaches 1 and is consumed, go to `RUN`.
  - A new `ex_br_taken` while in `FLUSH` reloads `flush_cnt = FLUSH_CYCLES-1`.
- **MEM_WAIT**
  - While `mstall`: all enables 0; `true_branch` 0; `hazard_stall` 0.
  - When `mstall` is 0: return to `FLUSH` if `ret_flush`, else `RUN`, and evaluate that state's rules in the same cycle (no dead cycle).

## Timing

- Reset values:
  - state `RUN`; `flush_cnt` 0; `ret_flush` 0.
  - All enables 1 (outputs are combinational from state and inputs, so with idle inputs they read 1).
  - `hazard_stall` 0; `true_branch` 0; perf counters 0.
- Latency: zero. Every output responds combinationally in the same cycle as its inputs.
- Load-use stall lasts exactly one cycle, because the bubble then occupies EX and `ex_is_load` drops.
- A redirect held under `mstall` stays visible: EX is frozen, so `ex_br_taken` persists until the stall releases.
- Reset mid-stall or mid-flush: asynchronous return to `RUN`; any pending flush is dropped.

## Configuration

- `PIPE_PERF_EN` defined: the three counters exist.
  - `perf_stall_cnt` increments each cycle `mstall` is 1.
  - `perf_flush_cnt` increments each cycle `true_branch` is 1.
  - `perf_lu_cnt` increments each cycle `hazard_stall` is 1.
  - All three saturate at all-ones and reset to 0.
- Undefined: the counter ports and their logic are absent; all other behaviour is identical.

## Test plan

- **Load-use:** `ex_is_load=1`, `ex_rd=5`, `id_rs2=5`, `id_use_rs2=1` → `hazard_stall=1`, `load_pc=0`, `load_if_id=0`, `load_id_ex=1` for one cycle. Repeat with `ex_rd=0` → no stall.
- **Flush window:** `FLUSH_CYCLES=3`, one-cycle `ex_br_taken` → `true_branch=1` for exactly 3 cycles, all enables 1; `lu` asserted in cycle 2 is ignored.
- **Stall inside flush:** `FLUSH_CYCLES=3`; `dmem_req=1`, `dmem_resp=0` for 4 cycles starting in flush cycle 2 → all enables 0 and `true_branch=0` during the stall. Afterwards `true_branch=1` for 2 more cycles, then `RUN`.
- **Priority:** `imem_req=1`, `imem_resp=0` together with `ex_br_taken=1` and `lu=1` → all outputs 0 until `imem_resp`. In the release cycle → `true_branch=1` and `hazard_stall=0`.
- **Reset:** assert `rst=0` asynchronously in the middle of `FLUSH` → state `RUN`, `true_branch=0` immediately, counters 0.
- **Counter saturation (`PIPE_PERF_EN`, `PERF_W=4`):** 20 consecutive `mstall` cycles → `perf_stall_cnt=15` and it holds.
